// File: rtl/nba_system.sv
// Number-baseball accelerator: a grader scores BCD guesses that a history-pruning solver generates.
// Reply is registered one cycle after the ask handshake; each side holds its offer until the peer is ready.
module nba_system #(
  parameter int MAX_Q      = 200,
  parameter int HIST_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] answer,
  output logic [15:0] question,
  output logic        ask_valid,
  output logic        ask_ready,
  output logic [2:0]  strike,
  output logic [2:0]  ball,
  output logic        reply_valid,
  output logic        reply_ready,
  output logic [15:0] cnt,
  output logic        correct
);
  localparam int HW = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;
  localparam int CW = $clog2(HIST_DEPTH + 1);

  // {strike, ball} of q against a, from nibble equality only
  function automatic logic [5:0] score(input logic [15:0] q, input logic [15:0] a);
    logic [2:0] s;
    logic [2:0] b;
    s = '0;
    b = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (q[4*i +: 4] == a[4*j +: 4]) begin
          if (i == j) s = s + 3'd1;
          else        b = b + 3'd1;
        end
    return {s, b};
  endfunction

  function automatic logic has_repeat(input logic [15:0] v);
    logic r;
    r = 1'b0;
    for (int i = 0; i < 4; i++)
      for (int j = i + 1; j < 4; j++)
        if (v[4*i +: 4] == v[4*j +: 4]) r = 1'b1;
    return r;
  endfunction

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++)
      if (carry) begin
        if (r[4*i +: 4] == 4'd9) r[4*i +: 4] = 4'd0;
        else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    return r;
  endfunction

  logic       reply_pending;
  logic [5:0] ask_score;
  logic       reply_hs;

  assign ask_score   = score(question, answer);
  assign ask_ready   = !reply_pending && !correct && (cnt < 16'(MAX_Q));
  assign reply_valid = reply_pending;
  assign reply_hs    = reply_valid && reply_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reply_pending <= 1'b0;
      cnt           <= '0;
      strike        <= '0;
      ball          <= '0;
      correct       <= 1'b0;
    end else if (ask_valid && ask_ready) begin
      reply_pending <= 1'b1;
      cnt           <= cnt + 16'd1;
      strike        <= ask_score[5:3];
      ball          <= ask_score[2:0];
      correct       <= (ask_score[5:3] == 3'd4);
    end else if (reply_hs) begin
      reply_pending <= 1'b0;
    end
  end

  typedef enum logic [2:0] {SEARCH, CHECK, ASK, WAIT, DONE} state_t;

  state_t        state;
  logic [15:0]   cand;
  logic [CW-1:0] hist_cnt;
  logic [CW-1:0] idx;
  logic [15:0]   hist_q [HIST_DEPTH];
  logic [5:0]    hist_r [HIST_DEPTH];
  logic [5:0]    chk_score;
  logic          hist_we;

  assign chk_score = score(cand, hist_q[idx[HW-1:0]]);
  assign hist_we   = (state == WAIT) && reply_hs && (hist_cnt < CW'(HIST_DEPTH));

  always_ff @(posedge clk) begin
    if (hist_we) begin
      hist_q[hist_cnt[HW-1:0]] <= question;
      hist_r[hist_cnt[HW-1:0]] <= {strike, ball};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= SEARCH;
      cand        <= '0;
      hist_cnt    <= '0;
      idx         <= '0;
      question    <= '0;
      ask_valid   <= 1'b0;
      reply_ready <= 1'b0;
    end else begin
      case (state)
        SEARCH: begin
          // Every value above 9876 repeats a digit, so nothing is left to try
          if (cand > 16'h9876)      state <= DONE;
          else if (has_repeat(cand)) cand <= bcd_inc(cand);
          else begin
            idx   <= '0;
            state <= CHECK;
          end
        end
        CHECK: begin
          if (idx == hist_cnt) begin
            question  <= cand;
            ask_valid <= 1'b1;
            state     <= ASK;
          end else if (chk_score != hist_r[idx[HW-1:0]]) begin
            cand  <= bcd_inc(cand);
            state <= SEARCH;
          end else begin
            idx <= idx + CW'(1);
          end
        end
        ASK: begin
          if (ask_valid && ask_ready) begin
            ask_valid   <= 1'b0;
            reply_ready <= 1'b1;
            state       <= WAIT;
          end
        end
        WAIT: begin
          if (reply_hs) begin
            reply_ready <= 1'b0;
            if (hist_cnt < CW'(HIST_DEPTH)) hist_cnt <= hist_cnt + CW'(1);
            if (correct) state <= DONE;
            else begin
              cand  <= bcd_inc(cand);
              state <= SEARCH;
            end
          end else begin
            reply_ready <= 1'b1;
          end
        end
        default: begin
          ask_valid   <= 1'b0;
          reply_ready <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_nba_system.sv
// Bench for nba_system: directed and random games scored by a decimal-arithmetic reference solver.
module tb_nba_system;
  localparam int MAX_Q      = 200;
  localparam int HIST_DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] answer = '0;
  logic [15:0] question;
  logic        ask_valid, ask_ready, reply_valid, reply_ready, correct;
  logic [2:0]  strike, ball;
  logic [15:0] cnt;

  nba_system #(.MAX_Q(MAX_Q), .HIST_DEPTH(HIST_DEPTH)) dut (
    .clk(clk), .reset(reset), .answer(answer), .question(question),
    .ask_valid(ask_valid), .ask_ready(ask_ready), .strike(strike), .ball(ball),
    .reply_valid(reply_valid), .reply_ready(reply_ready), .cnt(cnt), .correct(correct)
  );

  always #5 clk = ~clk;

  int comps = 0;
  int errs  = 0;
  int hq[HIST_DEPTH];
  int hs[HIST_DEPTH];
  int hb[HIST_DEPTH];
  int hn;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    comps++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int dg(input int v, input int i);
    return (i == 0) ? v / 1000 : (i == 1) ? (v / 100) % 10 : (i == 2) ? (v / 10) % 10 : v % 10;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(dg(v, 0)), 4'(dg(v, 1)), 4'(dg(v, 2)), 4'(dg(v, 3))};
  endfunction

  function automatic int from_bcd(input logic [15:0] b);
    return int'(b[15:12]) * 1000 + int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic bit distinct(input int v);
    for (int i = 0; i < 4; i++)
      for (int j = i + 1; j < 4; j++)
        if (dg(v, i) == dg(v, j)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int strikes(input int q, input int a);
    int s = 0;
    for (int i = 0; i < 4; i++) if (dg(q, i) == dg(a, i)) s++;
    return s;
  endfunction

  function automatic int balls(input int q, input int a);
    int b = 0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (i != j && dg(q, i) == dg(a, j)) b++;
    return b;
  endfunction

  // Smallest distinct-digit value >= from that agrees with every remembered reply
  function automatic int next_cand(input int from);
    for (int v = from; v <= 9876; v++) begin
      bit ok = distinct(v);
      for (int k = 0; k < hn && ok; k++)
        if (strikes(v, hq[k]) != hs[k] || balls(v, hq[k]) != hb[k]) ok = 1'b0;
      if (ok) return v;
    end
    return -1;
  endfunction

  task automatic play_game(input logic [15:0] ans, input int budget, input int stall_n,
                           input int abort_n, input bit expect_win, output int n);
    int  a, expq, es, eb, cyc;
    bit  won, aborted, seen_first;
    reset  = 1'b1;
    answer = ans;
    repeat (2) @(negedge clk);
    chk("rst_cnt", cnt, 0);
    chk("rst_correct", correct, 0);
    chk("rst_reply_valid", reply_valid, 0);
    chk("rst_strike_ball", {strike, ball}, 0);
    chk("rst_ask_valid", ask_valid, 0);
    chk("rst_reply_ready", reply_ready, 0);
    chk("rst_question", question, 0);
    reset = 1'b0;
    a = from_bcd(ans);
    hn = 0; n = 0; won = 1'b0; aborted = 1'b0; seen_first = 1'b0;
    expq = next_cand(0);
    for (cyc = 1; cyc <= budget && !won && !aborted; cyc++) begin
      @(negedge clk);
      if (ask_valid && !seen_first) begin
        seen_first = 1'b1;
        chk("first_q_within_128", cyc <= 128, 1);
      end
      if (ask_valid && ask_ready) begin
        if (expq < 0) begin
          chk("unexpected_question", question, 32'hFFFF_FFFF);
          aborted = 1'b1;
        end else begin
          chk("question", question, to_bcd(expq));
          es = strikes(expq, a);
          eb = balls(expq, a);
          @(negedge clk);
          cyc++;
          n++;
          chk("reply_valid", reply_valid, 1);
          chk("strike", strike, es);
          chk("ball", ball, eb);
          chk("cnt", cnt, n);
          chk("correct", correct, es == 4);
          if (n == stall_n) begin
            force dut.reply_ready = 1'b0;
            repeat (4) begin
              @(negedge clk);
              cyc++;
              chk("stall_reply_valid", reply_valid, 1);
              chk("stall_strike", strike, es);
              chk("stall_ball", ball, eb);
              chk("stall_ask_ready", ask_ready, 0);
              chk("stall_cnt", cnt, n);
            end
            release dut.reply_ready;
          end
          if (hn < HIST_DEPTH) begin
            hq[hn] = expq; hs[hn] = es; hb[hn] = eb; hn++;
          end
          if (n == abort_n)  aborted = 1'b1;
          else if (es == 4)  won = 1'b1;
          else               expq = next_cand(expq + 1);
        end
      end
    end
    if (abort_n == 0) begin
      chk("game_won", won, expect_win);
      if (!won) chk("missing_question", expq, -1);
      repeat (5) @(negedge clk);
      chk("done_ask_valid", ask_valid, 0);
      chk("done_reply_ready", reply_ready, 0);
      chk("final_cnt", cnt, n);
      chk("final_correct", correct, expect_win);
      chk("cnt_bound", cnt <= MAX_Q, 1);
    end
  endtask

  initial begin
    int n;
    int d[4];
    logic [15:0] rans;

    // Solved on the very first question
    play_game(16'h0123, 400, 0, 0, 1'b1, n);
    chk("0123_cnt_is_1", cnt, 1);
    chk("0123_final_q", question, 16'h0123);

    // Abort mid-game with cnt==3, then reset must clear outputs without a clock edge
    play_game(16'h3201, 30000, 0, 3, 1'b0, n);
    chk("pre_abort_cnt", cnt, 3);
    #2 reset = 1'b1;
    #1;
    chk("async_cnt", cnt, 0);
    chk("async_correct", correct, 0);
    chk("async_reply_valid", reply_valid, 0);
    chk("async_strike_ball", {strike, ball}, 0);
    chk("async_ask_valid", ask_valid, 0);
    chk("async_reply_ready", reply_ready, 0);
    chk("async_question", question, 0);

    // All-ball first reply, with the reply channel stalled on the first question
    play_game(16'h1032, 30000, 1, 0, 1'b1, n);

    play_game(16'h9876, 30000, 0, 0, 1'b1, n);
    chk("9876_cnt_le_10", cnt <= 10, 1);
    chk("9876_final_q", question, 16'h9876);

    repeat (2) begin
      d[0] = $urandom_range(0, 2);
      for (int i = 1; i < 4; i++) begin
        bit dup;
        do begin
          d[i] = $urandom_range(0, 9);
          dup = 1'b0;
          for (int j = 0; j < i; j++) if (d[j] == d[i]) dup = 1'b1;
        end while (dup);
      end
      rans = {4'(d[0]), 4'(d[1]), 4'(d[2]), 4'(d[3])};
      play_game(rans, 30000, 2, 0, 1'b1, n);
    end

    // Repeated digits: never solvable, solver must run out of candidates
    play_game(16'h1123, 25000, 0, 0, 1'b0, n);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", comps, errs);
    $finish;
  end
endmodule
